// File: rtl/lcd1602_ctrl.sv
// ---------------------------------------------------------------------------
// lcd1602_ctrl -- HD44780-compatible character LCD controller (1 or 2 rows).
//
// Holds a ROWS x COLS character frame buffer, runs the panel power-up /
// initialisation sequence after reset, then refreshes the whole panel from
// the buffer forever over the 8-bit parallel bus.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   wr_en    write one buffer byte this cycle (ignored while busy or on clr)
//   wr_addr  buffer index = row*COLS + col; indices >= ROWS*COLS are ignored
//   wr_data  character code
//   clr      start a sweep that fills the buffer with 0x20, one entry per clk
//   busy     clear sweep in progress
//   ready    initialisation done, refresh running
//   lcd_rs   register select (0 = command, 1 = data)
//   lcd_rw   read/write select, always write (0)
//   lcd_en   enable strobe
//   lcd_dat  data bus
//   lcd_n    backlight cathode (0)
//   lcd_p    backlight anode (1)
// ---------------------------------------------------------------------------
module lcd1602_ctrl #(
    parameter int CLK_DIV  = 16,
    parameter int COLS     = 16,
    parameter int ROWS     = 2,
    parameter int PWR_WAIT = 4,
    parameter int CLR_WAIT = 64,
    parameter int AW       = $clog2(ROWS*COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    output logic          busy,
    output logic          ready,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_dat,
    output logic          lcd_n,
    output logic          lcd_p
);

    localparam int N    = ROWS * COLS;
    localparam int IW   = $clog2(N);
    localparam int TW   = $clog2(CLK_DIV);
    localparam int WMAX = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int CW   = $clog2(COLS + 1);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_CLRW, S_ROWADR, S_DATA} state_t;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD} phase_t;

    assign lcd_rw = 1'b0;
    assign lcd_n  = 1'b0;
    assign lcd_p  = 1'b1;

    // ---------------- phase timer ----------------
    logic [TW-1:0] timer;
    logic          tick;

    assign tick = (timer == TW'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    timer <= '0;
        else if (tick) timer <= '0;
        else           timer <= timer + TW'(1);
    end

    // ---------------- frame buffer and clear sweep ----------------
    logic [7:0]    frame [N];
    logic [IW-1:0] clr_idx;
    logic          wr_in_range;

    assign wr_in_range = (int'(wr_addr) < N);

    // NOTE: the buffer is reset on purpose: the panel must show blanks (0x20)
    // straight after reset, so it is built from flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) frame[i] <= 8'h20;
            busy    <= 1'b0;
            clr_idx <= '0;
        end else if (busy) begin
            frame[clr_idx] <= 8'h20;
            if (clr_idx == IW'(N - 1)) begin
                busy    <= 1'b0;
                clr_idx <= '0;
            end else begin
                clr_idx <= clr_idx + IW'(1);
            end
        end else if (clr) begin
            // clr takes priority: a write in the same cycle is dropped
            busy    <= 1'b1;
            clr_idx <= '0;
        end else if (wr_en && wr_in_range) begin
            frame[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // ---------------- refresh FSM ----------------
    state_t        state;
    phase_t        phase;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    init_idx;
    logic          row;
    logic [CW-1:0] col;
    logic [CW-1:0] nxt_col;
    logic [IW-1:0] rd_idx;
    logic [7:0]    rd_byte;
    logic          next_row;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            2'd1:    return 8'h0C;  // display on, cursor off
            2'd2:    return 8'h06;  // increment, no shift
            default: return 8'h01;  // clear display
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic r);
        return r ? 8'hC0 : 8'h80;
    endfunction

    // Index of the byte loaded at the coming SETUP tick: col 0 after the row
    // address command, otherwise the column after the current one.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_col = '0;
        if (state == S_DATA && col != CW'(COLS - 1)) nxt_col = col + CW'(1);
        rd_idx = IW'(int'(row) * COLS + int'(nxt_col));
    end

    assign rd_byte  = frame[rd_idx];
    assign next_row = (ROWS == 2) ? ~row : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_PWR;
            phase    <= P_SETUP;
            wait_cnt <= '0;
            init_idx <= '0;
            row      <= 1'b0;
            col      <= '0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_dat  <= 8'h00;
            ready    <= 1'b0;
        end else if (tick) begin
            case (state)
                S_PWR: begin
                    if (wait_cnt == WW'(PWR_WAIT - 1)) begin
                        state    <= S_INIT;
                        phase    <= P_SETUP;
                        wait_cnt <= '0;
                        init_idx <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_dat  <= init_cmd(2'd0);
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_CLRW: begin
                    if (wait_cnt == WW'(CLR_WAIT - 1)) begin
                        ready    <= 1'b1;
                        state    <= S_ROWADR;
                        phase    <= P_SETUP;
                        wait_cnt <= '0;
                        row      <= 1'b0;
                        lcd_rs   <= 1'b0;
                        lcd_dat  <= row_cmd(1'b0);
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: begin
                    // S_INIT / S_ROWADR / S_DATA: one transfer per three phases
                    case (phase)
                        P_SETUP: begin
                            lcd_en <= 1'b1;
                            phase  <= P_PULSE;
                        end
                        P_PULSE: begin
                            lcd_en <= 1'b0;
                            phase  <= P_HOLD;
                        end
                        default: begin
                            // End of HOLD: this tick is the next SETUP tick,
                            // so rs/dat for the next transfer load here.
                            phase <= P_SETUP;
                            case (state)
                                S_INIT: begin
                                    if (init_idx == 2'd3) begin
                                        state    <= S_CLRW;
                                        wait_cnt <= '0;
                                    end else begin
                                        init_idx <= init_idx + 2'd1;
                                        lcd_dat  <= init_cmd(init_idx + 2'd1);
                                    end
                                end
                                S_ROWADR: begin
                                    state   <= S_DATA;
                                    col     <= '0;
                                    lcd_rs  <= 1'b1;
                                    lcd_dat <= rd_byte;
                                end
                                default: begin
                                    if (col == CW'(COLS - 1)) begin
                                        state   <= S_ROWADR;
                                        row     <= next_row;
                                        lcd_rs  <= 1'b0;
                                        lcd_dat <= row_cmd(next_row);
                                    end else begin
                                        col     <= nxt_col;
                                        lcd_dat <= rd_byte;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd1602_ctrl -- self-checking bench for lcd1602_ctrl.
//
// dut   : 2x16, CLK_DIV=2, PWR_WAIT=4, CLR_WAIT=4, AW=6 (so indices >= 32
//         can be presented on the write port).
// dut_b : 1x8, CLK_DIV=2;  dut_c : 1x8, CLK_DIV=5.
// Every lcd_en rise of dut is captured into a queue; expected transfers are
// pushed into a second queue and both are popped and compared in order.
// ---------------------------------------------------------------------------
module tb_lcd1602_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic       busy, ready, lcd_rs, lcd_rw, lcd_en, lcd_n, lcd_p;
    logic [7:0] lcd_dat;
    logic       b_busy, b_ready, b_rs, b_rw, b_en, b_n, b_p;
    logic [7:0] b_dat;
    logic       c_busy, c_ready, c_rs, c_rw, c_en, c_n, c_p;
    logic [7:0] c_dat;

    always #5 clk = ~clk;

    lcd1602_ctrl #(.CLK_DIV(2), .COLS(16), .ROWS(2), .PWR_WAIT(4), .CLR_WAIT(4), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .busy(busy), .ready(ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_dat(lcd_dat), .lcd_n(lcd_n), .lcd_p(lcd_p));

    lcd1602_ctrl #(.CLK_DIV(2), .COLS(8), .ROWS(1), .PWR_WAIT(4), .CLR_WAIT(4)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'h00),
        .clr(1'b0), .busy(b_busy), .ready(b_ready), .lcd_rs(b_rs), .lcd_rw(b_rw),
        .lcd_en(b_en), .lcd_dat(b_dat), .lcd_n(b_n), .lcd_p(b_p));

    lcd1602_ctrl #(.CLK_DIV(5), .COLS(8), .ROWS(1), .PWR_WAIT(4), .CLR_WAIT(4)) dut_c (
        .clk(clk), .rst_n(rst_b_n), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'h00),
        .clr(1'b0), .busy(c_busy), .ready(c_ready), .lcd_rs(c_rs), .lcd_rw(c_rw),
        .lcd_en(c_en), .lcd_dat(c_dat), .lcd_n(c_n), .lcd_p(c_p));

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- capture / scoreboard for dut ----------------
    typedef struct packed {logic rs; logic [7:0] dat;} xfer_t;
    typedef struct {xfer_t x; int cyc;} obs_t;

    obs_t  obs_q[$];
    xfer_t exp_q[$];
    int    pop_cyc[$];
    int    en_w_q[$];
    int    cyc = 0;
    int    tcyc = 0;
    int    ready_cyc = -1;
    int    en_rise = 0;
    logic  en_q = 1'b0;
    logic [7:0] mdl [32];

    // cycles since rst_n release: the first posedge after release reads 1
    always @(posedge clk) begin
        cyc  = rst_n ? cyc + 1 : 0;
        tcyc = tcyc + 1;
    end

    always @(negedge clk) begin
        obs_t o;
        if (!rst_n) begin
            en_q = 1'b0;
        end else begin
            if (lcd_en && !en_q) begin
                o.x   = {lcd_rs, lcd_dat};
                o.cyc = cyc;
                obs_q.push_back(o);
                en_rise = cyc;
            end
            if (!lcd_en && en_q) en_w_q.push_back(cyc - en_rise);
            if (ready && ready_cyc < 0) ready_cyc = cyc;
            en_q = lcd_en;
        end
    end

    // ---------------- single-row instances: checked on the fly ----------------
    int   b_idx = 0, b_last = -1, b_rows = 0, b_rise = 0;
    logic b_en_q = 1'b0;
    int   c_idx = 0, c_last = -1, c_rows = 0, c_rise = 0;
    logic c_en_q = 1'b0;

    always @(negedge clk) begin
        if (rst_b_n) begin
            if (b_en && !b_en_q) begin
                b_rise = tcyc;
                if (b_idx >= 4) begin
                    if (!b_rs) begin
                        check("B row cmd", 32'(b_dat), 32'h80);
                        if (b_last >= 0) check("B row cmd spacing", b_idx - b_last, 9);
                        b_last = b_idx;
                        b_rows++;
                    end else begin
                        check("B data", 32'(b_dat), 32'h20);
                    end
                end
                b_idx++;
            end
            if (!b_en && b_en_q) check("B en width", tcyc - b_rise, 2);
            b_en_q = b_en;

            if (c_en && !c_en_q) begin
                c_rise = tcyc;
                if (c_idx >= 4 && !c_rs) begin
                    check("C row cmd", 32'(c_dat), 32'h80);
                    if (c_last >= 0) check("C row cmd spacing", c_idx - c_last, 9);
                    c_last = c_idx;
                    c_rows++;
                end
                c_idx++;
            end
            if (!c_en && c_en_q) check("C en width", tcyc - c_rise, 5);
            c_en_q = c_en;
        end
    end

    // ---------------- helpers ----------------
    task automatic flush();
        obs_q.delete();
        en_w_q.delete();
        pop_cyc.delete();
    endtask

    // discard captured transfers until the given command is seen
    task automatic sync_cmd(input logic [7:0] cmd, input string name);
        obs_t o;
        int   n;
        bit   found;
        n = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                if (o.x == {1'b0, cmd}) found = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) timeout(name);
    endtask

    task automatic drain(input string name);
        obs_t  o;
        xfer_t e;
        int    n;
        int    k;
        k = 0;
        while (exp_q.size() != 0) begin
            n = 0;
            while (obs_q.size() == 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                timeout($sformatf("%s[%0d] want 0x%0h", name, k, e));
                exp_q.delete();
            end else begin
                o = obs_q.pop_front();
                pop_cyc.push_back(o.cyc);
                check($sformatf("%s[%0d]", name, k), 32'(o.x), 32'(e));
            end
            k++;
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    // expected transfers of one pass following the 0x80 command
    task automatic push_frame();
        for (int r = 0; r < 2; r++) begin
            if (r == 1) exp_q.push_back({1'b0, 8'hC0});
            for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mdl[r*16 + c]});
        end
    endtask

    task automatic check_pass(input string name);
        flush();
        sync_cmd(8'h80, {name, " sync"});
        push_frame();
        drain(name);
    endtask

    task automatic write(input logic [5:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " lcd_en"},  32'(lcd_en),  32'h0);
        check({tag, " lcd_rs"},  32'(lcd_rs),  32'h0);
        check({tag, " lcd_dat"}, 32'(lcd_dat), 32'h0);
        check({tag, " ready"},   32'(ready),   32'h0);
        check({tag, " busy"},    32'(busy),    32'h0);
        check({tag, " lcd_rw"},  32'(lcd_rw),  32'h0);
        check({tag, " lcd_n"},   32'(lcd_n),   32'h0);
        check({tag, " lcd_p"},   32'(lcd_p),   32'h1);
    endtask

    // ---------------- write vector table ----------------
    typedef struct {logic [5:0] addr; logic [7:0] data; bit lands;} wvec_t;
    wvec_t wtab [6];

    initial begin
        int n;
        wtab[0] = '{6'd0,  8'h41, 1'b1};
        wtab[1] = '{6'd31, 8'h5A, 1'b1};
        wtab[2] = '{6'd32, 8'h77, 1'b0};   // first out-of-range index
        wtab[3] = '{6'd63, 8'h66, 1'b0};
        wtab[4] = '{6'd17, 8'h42, 1'b1};
        wtab[5] = '{6'd5,  8'h35, 1'b1};
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

        // reset state
        repeat (3) @(negedge clk);
        check_reset("reset");

        // release: init sequence, first pass of blanks
        rst_n   = 1'b1;
        rst_b_n = 1'b1;
        flush();
        push_init();
        exp_q.push_back({1'b0, 8'h80});
        push_frame();
        drain("init");
        if (pop_cyc.size() >= 2) begin
            check("first en rise cycle", pop_cyc[0], 10);
            check("transfer spacing", pop_cyc[1] - pop_cyc[0], 6);
        end else begin
            timeout("init capture");
        end
        check("ready rise cycle", ready_cyc, 40);
        if (en_w_q.size() != 0) check("A en width", en_w_q[0], 2);
        else timeout("A en width");

        // table of writes, including out-of-range indices
        for (int i = 0; i < 6; i++) begin
            write(wtab[i].addr, wtab[i].data);
            if (wtab[i].lands) mdl[wtab[i].addr[4:0]] = wtab[i].data;
        end
        check_pass("write pass");

        // clear sweep with a write attempted while busy
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin
                wr_addr = 6'd3;
                wr_data = 8'h99;
                wr_en   = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("busy width", n, 32);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        check_pass("clear pass");

        // clr and wr_en in the same cycle: clr wins
        write(6'd5, 8'h11);
        write(6'd20, 8'h44);
        wr_addr = 6'd5;
        wr_data = 8'h33;
        wr_en   = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        clr   = 1'b0;
        check("busy after clr+wr", 32'(busy), 32'h1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("clr+wr busy");
        check_pass("clr+wr pass");

        // reset in the middle of a data PULSE phase
        n = 0;
        while (!(lcd_en && lcd_rs) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(lcd_en && lcd_rs)) timeout("wait data pulse");
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid-pulse reset");
        @(negedge clk);
        rst_n = 1'b1;
        flush();
        push_init();
        drain("re-init");
        if (pop_cyc.size() != 0) check("re-init first rise", pop_cyc[0], 10);
        else timeout("re-init capture");

        // single-row instances must have produced a steady stream
        check("B row cmds seen", 32'(b_rows >= 5), 32'h1);
        check("C row cmds seen", 32'(c_rows >= 2), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/lcd1602_ctrl.md
# lcd1602_ctrl

Parametrised HD44780-compatible character LCD controller for 1- or 2-row panels. It holds a ROWS×COLS character frame buffer written through a simple addressed port. After power-up it runs the panel initialisation sequence, then refreshes the whole panel continuously from the buffer over the 8-bit parallel bus. It drives the panel pins and backlight directly and sits between the system logic (UART/Nios data path) and the LCD header.

## Interface
- CLK_DIV, 16 — clk cycles per LCD phase (≥2)
- COLS, 16 — characters per row (1..40)
- ROWS, 2 — rows (1 or 2)
- PWR_WAIT, 4 — phases idled after reset before the first command
- CLR_WAIT, 64 — phases idled after the 0x01 clear command
- AW, $clog2(ROWS*COLS) — write address width (derived)

Ports (clock and reset first):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one buffer byte this cycle
- wr_addr  in  AW  buffer index = row*COLS + col
- wr_data  in  8  character code
- clr  in  1  fill the buffer with 0x20
- busy  out  1  clear sweep in progress
- ready  out  1  init done, refresh running
- lcd_rs  out  1  register select (0 = command, 1 = data)
- lcd_rw  out  1  tied to 0
- lcd_en  out  1  enable strobe
- lcd_dat  out  8  data bus
- lcd_n  out  1  backlight cathode, tied to 0
- lcd_p  out  1  backlight anode, tied to 1

## Operation
- Phase timer: counts 0..CLK_DIV-1. A phase tick is asserted on the count of CLK_DIV-1, then the timer wraps to 0.
- Transfer: three phases, SETUP (en=0, rs/dat driven), PULSE (en=1), HOLD (en=0). rs/dat stay stable through all three phases.
- FSM states:
  - PWR: idle for PWR_WAIT phases.
  - INIT: sends 0x38, 0x0C, 0x06, 0x01 in order.
  - CLRW: idle for CLR_WAIT phases; ready rises on exit.
  - ROWADR: sends a command, 0x80 for row 0 and 0xC0 for row 1.
  - DATA: sends COLS data bytes for the current row, col 0..COLS-1.
  - After the last col: go to ROWADR of the next row, wrapping row ROWS-1 → 0. Loop forever.
- DATA reads buffer[row*COLS+col] at the SETUP tick. A buffer write landing after that tick shows on the next refresh pass.
- Buffer: ROWS*COLS registers.
  - A write with wr_addr ≥ ROWS*COLS is ignored.
  - wr_en is ignored while busy.
- clr: starts a sweep that writes 0x20 to one entry per clk, index 0..ROWS*COLS-1. busy is high for exactly ROWS*COLS cycles.
  - clr while busy is ignored.
  - clr and wr_en in the same cycle: clr wins, the write is dropped.
- The refresh FSM and the clear sweep run independently. The refresh may display a partially cleared frame.

## Timing
- Reset values (async, immediate on rst_n low):
  - lcd_en=0, lcd_rs=0, lcd_dat=0x00, ready=0, busy=0
  - lcd_rw=0, lcd_n=0, lcd_p=1
  - all buffer entries 0x20
  - FSM in PWR, phase timer 0
- Reset mid-transfer: lcd_en drops the same instant. After release, the full init sequence restarts.
- Write latency: buffer updated on the clk edge that samples wr_en.
- Time from rst_n release to the first lcd_en rise: (PWR_WAIT+1)*CLK_DIV clk.
- One transfer takes 3*CLK_DIV clk. lcd_en is high for exactly CLK_DIV clk per transfer.
- ready rises at the end of CLRW, after (PWR_WAIT + 4*3 + CLR_WAIT)*CLK_DIV clk from reset release.
- One full refresh takes ROWS*(COLS+1)*3*CLK_DIV clk.

## Test plan
- Reset/init (CLK_DIV=2, PWR_WAIT=4, CLR_WAIT=4):
  - Release rst_n, capture bytes on each lcd_en rise.
  - Required: 0x38, 0x0C, 0x06, 0x01 with rs=0, first rise 10 clk after release.
  - ready high 40 clk after release.
  - Then 0x80, then 16×0x20 with rs=1, then 0xC0.
- Write visibility: after ready, write 0x41 to addr 0 and 0x5A to addr 31. Required: next pass shows 0x41 as the first data after 0x80 and 0x5A as the last data after 0xC0.
- Out-of-range and busy:
  - Write addr 32 (COLS=16, ROWS=2): the following pass is unchanged.
  - Pulse clr, then write during busy: busy high exactly 32 clk, the write is dropped, all 32 bytes read back as 0x20.
- clr and wr_en in the same cycle at addr 5 with 0x33: addr 5 shows 0x20.
- Reset mid-PULSE: lcd_en goes low asynchronously, all outputs at reset values, the init sequence repeats from 0x38.
- Parameter sweep, ROWS=1, COLS=8:
  - No 0xC0 is ever sent; 0x80 repeats every 9 transfers.
  - lcd_en high width is CLK_DIV clk for CLK_DIV ∈ {2, 5}.
